sevenseg_scan_decoder: RTL

//  Reverse of the BCD-to-seven-segment encoder. Watches a multiplexed seven-segment display bus:

---
 rtl/sevenseg_scan_decoder.sv | 97 +++++++++
 1 files changed

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: stability-filtered readback decoder for a multiplexed seven-segment bus
module sevenseg_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] value,
  output logic              frame_valid,
  output logic              digits_ok,
  output logic              pat_err,
  output logic              sel_err
);
  localparam int W  = NDIG + 7;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] SMAX = CW'(STABLE_CYC);
  logic [W-1:0] s1, s;
  logic [CW-1:0] cnt, cnt_n;
  logic acc, acc_n, chg, one_hot, multi_hot, legal, done;
  logic [4*NDIG-1:0] nib, nib_n;
  logic [NDIG-1:0] ok, ok_n, seen, seen_n, sel;
  logic [4:0] dec;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction
  // stability tracking, pattern decode and next slot/seen state for the accepted sample
  always_comb begin
    chg = s1 != s;
    cnt_n = chg ? CW'(1) : (cnt == SMAX ? SMAX : cnt + CW'(1));
    acc_n = cnt_n == SMAX && (chg || cnt != SMAX);
    sel = s[W-1:7];
    dec = decode(s[6:0]);
    legal = dec[4];
    one_hot = sel != '0 && (sel & (sel - NDIG'(1))) == '0;
    multi_hot = sel != '0 && !one_hot;
    nib_n = nib;
    ok_n = ok;
    for (int i = 0; i < NDIG; i++)
      if (acc && one_hot && sel[i]) begin
        nib_n[4*i +: 4] = dec[3:0];
        ok_n[i] = legal;
      end
    seen_n = acc && one_hot ? seen | sel : seen;
    done = acc && one_hot && seen_n == '1;
  end
  // synchronizer, counter, slot registers and registered frame/flag outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s <= '0;
      cnt <= '0;
      acc <= 1'b0;
      nib <= '0;
      ok <= '0;
      seen <= '0;
      value <= '0;
      digits_ok <= 1'b0;
      frame_valid <= 1'b0;
      pat_err <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      s1 <= {dig_sel, seg_in};
      s <= s1;
      cnt <= cnt_n;
      acc <= acc_n;
      nib <= nib_n;
      ok <= ok_n;
      seen <= done ? '0 : seen_n;
      frame_valid <= done;
      pat_err <= acc && one_hot && !legal;
      sel_err <= acc && multi_hot;
      if (done) begin
        value <= nib_n;
        digits_ok <= &ok_n;
      end
    end
endmodule
